// File: rtl/instr_trace.sv
// Instruction retire trace buffer: decodes retired MIPS32 words to ASCII mnemonics
// and queues them in a show-ahead FIFO, with a trigger/post-trigger freeze.
module instr_trace #(
  parameter int LANES     = 1,
  parameter int DEPTH     = 8,
  parameter int POST_TRIG = 4,
  parameter int ASCII_W   = 48
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  trace_en,
  input  logic                  clear,
  input  logic [LANES-1:0]      retire_valid,
  input  logic [32*LANES-1:0]   retire_pc,
  input  logic [32*LANES-1:0]   retire_instr,
  input  logic [31:0]           trig_instr,
  input  logic [31:0]           trig_mask,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [31:0]           trace_pc,
  output logic [31:0]           trace_instr,
  output logic [ASCII_W-1:0]    trace_ascii,
  output logic [15:0]           trace_seq,
  output logic [1:0]            state,
  output logic [31:0]           retire_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    FROZEN  = 2'd3
  } state_t;

  // Mnemonics are right-aligned; unused leading bytes stay zero.
  function automatic logic [ASCII_W-1:0] decode(input logic [31:0] ins);
    logic [ASCII_W-1:0] m;
    m = "N-R";
    if (ins == 32'h0000_0000) m = "NOP";
    else if (ins == 32'h4200_0018) m = "ERET";
    else begin
      case (ins[31:26])
        6'h00: begin
          case (ins[5:0])
            6'h00: m = "SLL";   6'h02: m = "SRL";   6'h03: m = "SRA";
            6'h04: m = "SLLV";  6'h06: m = "SRLV";  6'h07: m = "SRAV";
            6'h08: m = "JR";    6'h09: m = "JALR";  6'h0C: m = "SYSC";
            6'h0D: m = "BRE";   6'h10: m = "MFHI";  6'h11: m = "MTHI";
            6'h12: m = "MFLO";  6'h13: m = "MTLO";  6'h18: m = "MULT";
            6'h19: m = "MULTU"; 6'h1A: m = "DIV";   6'h1B: m = "DIVU";
            6'h20: m = "ADD";   6'h21: m = "ADDU";  6'h22: m = "SUB";
            6'h23: m = "SUBU";  6'h24: m = "AND";   6'h25: m = "OR";
            6'h26: m = "XOR";   6'h27: m = "NOR";   6'h2A: m = "SLT";
            6'h2B: m = "SLTU";
            default: m = "N-R";
          endcase
        end
        6'h01: begin
          case (ins[20:16])
            5'h00: m = "BLTZ";   5'h01: m = "BGEZ";
            5'h10: m = "BLTZAL"; 5'h11: m = "BGEZAL";
            default: m = "N-R";
          endcase
        end
        6'h02: m = "J";     6'h03: m = "JAL";   6'h04: m = "BEQ";
        6'h05: m = "BNE";   6'h06: m = "BLEZ";  6'h07: m = "BGTZ";
        6'h08: m = "ADDI";  6'h09: m = "ADDIU"; 6'h0A: m = "SLTI";
        6'h0B: m = "SLTIU"; 6'h0C: m = "ANDI";  6'h0D: m = "ORI";
        6'h0E: m = "XORI";  6'h0F: m = "LUI";
        6'h10: begin
          case (ins[25:21])
            5'h00: m = "MFC0";
            5'h04: m = "MTC0";
            default: m = "N-R";
          endcase
        end
        6'h20: m = "LB";    6'h21: m = "LH";    6'h23: m = "LW";
        6'h24: m = "LBU";   6'h25: m = "LHU";   6'h28: m = "SB";
        6'h29: m = "SH";    6'h2B: m = "SW";
        default: m = "N-R";
      endcase
    end
    return m;
  endfunction

  state_t              state_reg, state_next;
  logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic [CW-1:0]       post_reg, post_next;
  logic [31:0]         retire_cnt_reg;
  logic [15:0]         drop_cnt_reg, drop_cnt_next;

  logic [31:0]         mem_pc    [DEPTH];
  logic [31:0]         mem_instr [DEPTH];
  logic [ASCII_W-1:0]  mem_ascii [DEPTH];
  logic [15:0]         mem_seq   [DEPTH];

  logic [ASCII_W-1:0]  lane_ascii [LANES];
  logic [LANES-1:0]    lane_hit;
  logic [LANES-1:0]    lane_push;
  logic [CW-1:0]       lane_off [LANES];
  logic [15:0]         lane_seq [LANES];

  logic                pop;
  logic [CW-1:0]       space;
  logic [CW-1:0]       n_push, n_drop;
  logic [31:0]         n_valid;
  logic [16:0]         drop_sum;
  state_t              cur;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_ascii[gi] = decode(retire_instr[32*gi +: 32]);
    assign lane_hit[gi]   = (trig_mask != 32'd0) &&
                            ((retire_instr[32*gi +: 32] & trig_mask) == (trig_instr & trig_mask));
  end

  assign pop = trace_valid && trace_ready;

  // Lanes are walked in order so a trigger or freeze on lane 0 already
  // governs lane 1 in the same cycle.
  always_comb begin
    cur       = state_reg;
    post_next = post_reg;
    n_push    = '0;
    n_drop    = '0;
    n_valid   = '0;
    lane_push = '0;
    space     = CW'(DEPTH) - count_reg + CW'(pop);
    for (int i = 0; i < LANES; i++) begin
      lane_off[i] = '0;
      lane_seq[i] = retire_cnt_reg[15:0] + n_valid[15:0];
      if (retire_valid[i]) begin
        n_valid = n_valid + 32'd1;
        if (!clear && (cur == CAPTURE || cur == POST)) begin
          if (n_push < space) begin
            lane_push[i] = 1'b1;
            lane_off[i]  = n_push;
            n_push       = n_push + CW'(1);
            if (cur == CAPTURE) begin
              if (lane_hit[i]) begin
                if (POST_TRIG == 0) begin
                  cur = FROZEN;
                end else begin
                  cur       = POST;
                  post_next = '0;
                end
              end
            end else begin
              post_next = post_next + CW'(1);
              if (post_next == CW'(POST_TRIG)) cur = FROZEN;
            end
          end else begin
            n_drop = n_drop + CW'(1);
          end
        end
      end
    end

    if (!trace_en)                state_next = IDLE;
    else if (clear)               state_next = CAPTURE;
    else if (state_reg == IDLE)   state_next = CAPTURE;
    else                          state_next = cur;

    drop_sum      = {1'b0, drop_cnt_reg} + 17'(n_drop);
    drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      post_reg       <= '0;
      retire_cnt_reg <= '0;
      drop_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg != IDLE) retire_cnt_reg <= retire_cnt_reg + n_valid;
      if (clear) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
        post_reg     <= '0;
        drop_cnt_reg <= '0;
      end else begin
        wr_ptr_reg   <= wr_ptr_reg + PW'(n_push);
        rd_ptr_reg   <= rd_ptr_reg + PW'(pop);
        count_reg    <= count_reg + n_push - CW'(pop);
        post_reg     <= post_next;
        drop_cnt_reg <= drop_cnt_next;
      end
    end
  end

  // Storage has no reset; emptiness is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_push[i]) begin
        mem_pc   [wr_ptr_reg + lane_off[i][PW-1:0]] <= retire_pc[32*i +: 32];
        mem_instr[wr_ptr_reg + lane_off[i][PW-1:0]] <= retire_instr[32*i +: 32];
        mem_ascii[wr_ptr_reg + lane_off[i][PW-1:0]] <= lane_ascii[i];
        mem_seq  [wr_ptr_reg + lane_off[i][PW-1:0]] <= lane_seq[i];
      end
    end
  end

  assign trace_valid = (count_reg != '0);
  assign trace_pc    = trace_valid ? mem_pc[rd_ptr_reg]    : '0;
  assign trace_instr = trace_valid ? mem_instr[rd_ptr_reg] : '0;
  assign trace_ascii = trace_valid ? mem_ascii[rd_ptr_reg] : '0;
  assign trace_seq   = trace_valid ? mem_seq[rd_ptr_reg]   : '0;
  assign state       = state_reg;
  assign retire_cnt  = retire_cnt_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: doc/instr_trace.md
INSTR_TRACE -- requirements
Module: instr_trace

Interface
REQ-001 SHALL have parameter LANES, default 1, retire lanes per cycle; legal values 1 or 2.
REQ-002 SHALL have parameter DEPTH, default 8, trace FIFO entries; power of two, 2..64.
REQ-003 SHALL have parameter POST_TRIG, default 4, entries captured after a trigger hit; 0..DEPTH-1.
REQ-004 SHALL have parameter ASCII_W, default 48, mnemonic width in bits (6 chars).
REQ-005 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port resetn  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have port trace_en  in  1  capture enable.
REQ-008 SHALL have port clear  in  1  single-cycle pulse; flushes the FIFO and rearms.
REQ-009 SHALL have port retire_valid  in  LANES  per-lane retire strobe.
REQ-010 SHALL have port retire_pc  in  32*LANES  per-lane PC; lane i at bits [32i+31:32i].
REQ-011 SHALL have port retire_instr  in  32*LANES  per-lane instruction word.
REQ-012 SHALL have port trig_instr, trig_mask  in  32 each  trigger pattern and mask.
REQ-013 SHALL have port trace_valid  out  1  FIFO not empty.
REQ-014 SHALL have port trace_ready  in  1  consumer pop; a pop occurs when trace_valid && trace_ready.
REQ-015 SHALL have ports trace_pc and trace_instr (out, 32), trace_ascii (out, ASCII_W) and trace_seq (out, 16), all from the FIFO head.
REQ-016 SHALL have ports state (out, 2), retire_cnt (out, 32) and drop_cnt (out, 16).

Function
REQ-017 SHALL decode each pushed instruction to an ASCII mnemonic, right-aligned with zero-byte padding, and store it in the entry.
- Decode set: all MIPS32 R-type ALU, shift, HI/LO, mult/div, JR/JALR ops, plus SYSCALL as "SYSC" and BREAK as "BRE".
- Decode set: I/J, branch, load/store, REGIMM (BGEZ, BGEZAL, BLTZ, BLTZAL) and COP0 (MTC0, MFC0).
REQ-018 SHALL decode 0x00000000 as "NOP" and 0x42000018 as "ERET"; these two take priority over the table.
REQ-019 SHALL decode any unlisted encoding, including unknown REGIMM rt or COP0 rs, as "N-R".
REQ-020 SHALL implement states IDLE=0, CAPTURE=1, POST=2, FROZEN=3.
- Any state -> IDLE when trace_en=0; the FIFO is kept.
- IDLE -> CAPTURE when trace_en=1.
- CAPTURE -> POST when a pushed entry matches (instr & trig_mask) == (trig_instr & trig_mask) and trig_mask != 0; with POST_TRIG=0 this goes directly to FROZEN.
- POST -> FROZEN after POST_TRIG further entries are pushed.
REQ-021 SHALL push retired lanes only in CAPTURE or POST; lane 0 orders before lane 1 in the same cycle.
REQ-022 SHALL compute free space as DEPTH - count, plus 1 when a pop occurs in the same cycle.
- Lanes are accepted in order while space remains.
- Each rejected valid lane increments drop_cnt, saturating at 0xFFFF.
REQ-023 SHALL, in FROZEN or IDLE, ignore retire lanes without counting them as drops; pops remain allowed.
REQ-024 SHALL increment retire_cnt (wrapping) by the number of valid lanes in every non-IDLE cycle, including FROZEN and dropped lanes.
REQ-025 SHALL tag each pushed entry with trace_seq = retire_cnt value before increment, plus the lane offset, truncated to 16 bits, so drops show up as gaps.
REQ-026 SHALL present FIFO-head outputs show-ahead: entry visible the cycle after push; pointers wrap modulo DEPTH.
REQ-027 SHALL, when clear is asserted, empty the FIFO, zero drop_cnt and the post counter, and enter CAPTURE if trace_en=1 else IDLE.
- clear overrides any same-cycle push or pop.
- clear does not zero retire_cnt.
REQ-028 SHALL hold head outputs stable while trace_valid=1 and trace_ready=0.

Reset
REQ-029 SHALL, on resetn low, immediately force: state=IDLE, FIFO empty, trace_valid=0, trace_pc/instr/ascii/seq=0, retire_cnt=0, drop_cnt=0, post counter=0.
REQ-030 SHALL discard in-flight pushes when reset asserts mid-operation, and resume from IDLE on the first edge after release.

Verification
REQ-031 SHALL verify: LANES=1, trace_en=1, retire instr 0x00851020 at pc 0xBFC00000 -> next cycle trace_valid=1, trace_ascii="ADD", trace_seq=0.
REQ-032 SHALL verify: push 0x00000000, 0x42000018, 0x04110004, 0x04050000 -> ascii "NOP", "ERET", "BGEZAL", "N-R" in order.
REQ-033 SHALL verify: DEPTH=8, trace_ready=0, 10 retires -> 8 entries, drop_cnt=2, retire_cnt=10; seq 0..7 drained in order.
REQ-034 SHALL verify: LANES=2, FIFO at 7/8, both lanes valid with a same-cycle pop -> both accepted, drop_cnt=0.
REQ-035 SHALL verify: trig_mask=0xFC000000, trig_instr=0x0C000000 (JAL), POST_TRIG=4 -> after JAL plus 4 pushes state=3, further retires not stored and not dropped; clear -> FIFO empty, state=1.
REQ-036 SHALL verify: resetn pulsed low mid-burst -> all outputs zero asynchronously, state=0.
